// File: rtl/qreg_ctl_pkg.sv
// Shared encodings for the Q register control slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package qreg_ctl_pkg;

  // Effective Q operation, as driven on {qs1,qs0}
  typedef enum logic [1:0] {
    Q_HOLD = 2'b00,
    Q_SHL  = 2'b01,
    Q_SHR  = 2'b10,
    Q_LOAD = 2'b11
  } q_op_t;

  // Shift sequencer states
  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/qreg_ctl_if.sv
// Bundle of machine-state, IR, ALU and sequencer signals around the Q register.
// Latency: n/a (wiring only).
// Backpressure: none; the sequencer simply ignores starts while busy.
interface qreg_ctl_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
);
  logic             state_alu;
  logic             state_write;
  logic             state_mmu;
  logic             state_fetch;
  logic [1:0]       ir_q;
  logic             iralu;
  logic             srcq;
  logic [WIDTH-1:0] alu;
  logic             seq_start;
  logic             seq_dir;
  logic [CNT_W-1:0] seq_count;
  logic [WIDTH-1:0] q;
  logic             qs0;
  logic             qs1;
  logic             qdrive;
  logic             seq_busy;
  logic             seq_done;

  // Machine control / stimulus side
  modport master (
    output state_alu, state_write, state_mmu, state_fetch,
    output ir_q, iralu, srcq, alu, seq_start, seq_dir, seq_count,
    input  q, qs0, qs1, qdrive, seq_busy, seq_done
  );

  // Q control block side
  modport slave (
    input  state_alu, state_write, state_mmu, state_fetch,
    input  ir_q, iralu, srcq, alu, seq_start, seq_dir, seq_count,
    output q, qs0, qs1, qdrive, seq_busy, seq_done
  );
endinterface

// File: rtl/qreg_seq.sv
// Autonomous shift sequencer: issues N shift steps, one per write-state cycle.
// Latency: busy from the cycle after start; done pulses the cycle after the last step.
// Backpressure: starts while running are dropped; steps stall until state_write.
module qreg_seq
  import qreg_ctl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             state_write,
  input  logic             seq_start,
  input  logic             seq_dir,
  input  logic [CNT_W-1:0] seq_count,
  output logic             seq_busy,
  output logic             seq_done,
  output logic [1:0]       ovr_sel
);

  seq_state_t       state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic             dir_r, dir_n;
  logic             done_r, done_n;

  // State, counter, direction and done-pulse registers; reset dominates
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= SEQ_IDLE;
      cnt_r   <= '0;
      dir_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      dir_r   <= dir_n;
      done_r  <= done_n;
    end
  end

  // Next-state: latch a non-empty request, count steps down on write cycles
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    dir_n   = dir_r;
    done_n  = 1'b0;
    case (state_r)
      SEQ_IDLE: begin
        if (seq_start) begin
          if (seq_count != '0) begin
            state_n = SEQ_RUN;
            cnt_n   = seq_count;
            dir_n   = seq_dir;
          end else begin
            // Empty request completes immediately without touching Q
            done_n = 1'b1;
          end
        end
      end
      SEQ_RUN: begin
        if (state_write) begin
          cnt_n = cnt_r - 1'b1;
          if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_n = SEQ_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = SEQ_IDLE;
    endcase
  end

  assign seq_busy = (state_r == SEQ_RUN);
  assign seq_done = done_r;
  assign ovr_sel  = dir_r ? Q_SHR : Q_SHL;

endmodule

// File: rtl/qreg_ctl.sv
// Q register with IR-decoded hold/shift/load and an autonomous shift sequencer.
// Latency: Q updates on the edge ending a write-state cycle; selects/qdrive are combinational.
// Backpressure: none; the sequencer owns the selects while busy and IR Q ops are ignored.
module qreg_ctl
  import qreg_ctl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       reset,
  qreg_ctl_if.slave  bus
);

  logic [WIDTH-1:0] q_r;
  logic [1:0]       sel;
  logic [1:0]       ovr_sel;
  logic             seq_busy;

  qreg_seq #(.CNT_W(CNT_W)) u_seq (
    .clk         (clk),
    .reset       (reset),
    .state_write (bus.state_write),
    .seq_start   (bus.seq_start),
    .seq_dir     (bus.seq_dir),
    .seq_count   (bus.seq_count),
    .seq_busy    (seq_busy),
    .seq_done    (bus.seq_done),
    .ovr_sel     (ovr_sel)
  );

  // Effective select: sequencer override while busy, else IR field gated by iralu
  always_comb begin
    sel = bus.ir_q & {2{bus.iralu}};
    if (seq_busy) sel = ovr_sel;
  end

  // Q datapath: only the write state changes Q
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= '0;
    end else if (bus.state_write) begin
      case (sel)
        Q_SHL:   q_r <= {q_r[WIDTH-2:0], ~bus.alu[WIDTH-1]};
        Q_SHR:   q_r <= {bus.alu[0], q_r[WIDTH-1:1]};
        Q_LOAD:  q_r <= bus.alu;
        default: q_r <= q_r;
      endcase
    end
  end

  assign bus.q        = q_r;
  assign bus.qs0      = sel[0];
  assign bus.qs1      = sel[1];
  assign bus.seq_busy = seq_busy;
  assign bus.qdrive   = bus.srcq & (bus.state_alu | bus.state_write |
                                    bus.state_mmu | bus.state_fetch);

endmodule

// File: tb/tb_qreg_ctl.sv
// Self-checking bench for qreg_ctl: scoreboard of expected outputs per checkpoint.
// Latency: one clock per tick, outputs sampled 1ns after the rising edge.
// Backpressure: n/a.
module tb_qreg_ctl;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  localparam int K_Q    = 0;
  localparam int K_BUSY = 1;
  localparam int K_DONE = 2;
  localparam int K_SEL  = 3;
  localparam int K_DRV  = 4;

  logic clk = 1'b0;
  logic reset;

  qreg_ctl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  qreg_ctl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  int          sb_kind[$];
  string       sb_tag[$];
  logic [31:0] sb_exp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input int kind, input string tag, input logic [31:0] v);
    sb_kind.push_back(kind);
    sb_tag.push_back(tag);
    sb_exp.push_back(v);
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_Q:     return bus.q;
      K_BUSY:  return {31'b0, bus.seq_busy};
      K_DONE:  return {31'b0, bus.seq_done};
      K_SEL:   return {30'b0, bus.qs1, bus.qs0};
      default: return {31'b0, bus.qdrive};
    endcase
  endfunction

  // Pop every pending expectation and compare against the DUT now
  task automatic sb_check();
    while (sb_kind.size() > 0) begin
      int k;
      string t;
      logic [31:0] e;
      k = sb_kind.pop_front();
      t = sb_tag.pop_front();
      e = sb_exp.pop_front();
      chk(t, observe(k), e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.state_alu   = 1'b0;
    bus.state_write = 1'b0;
    bus.state_mmu   = 1'b0;
    bus.state_fetch = 1'b0;
    bus.ir_q        = 2'b00;
    bus.iralu       = 1'b0;
    bus.srcq        = 1'b0;
    bus.seq_start   = 1'b0;
    bus.seq_dir     = 1'b0;
    bus.seq_count   = '0;
  endtask

  // IR load of a value through one write cycle
  task automatic ir_load(input logic [31:0] v);
    bus.iralu = 1'b1; bus.ir_q = 2'b11; bus.alu = v; bus.state_write = 1'b1;
    tick();
    bus.state_write = 1'b0; bus.iralu = 1'b0; bus.ir_q = 2'b00;
  endtask

  initial begin
    int dones;
    int busy_writes;
    int busy_seen;
    logic [3:0] st;

    idle_inputs();
    bus.alu = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    exp_push(K_Q,    "rst_q",    32'h0);
    exp_push(K_BUSY, "rst_busy", 32'h0);
    exp_push(K_DONE, "rst_done", 32'h0);
    tick();
    sb_check();

    // Load through IR, then ALU state alone must not disturb Q
    exp_push(K_Q, "load", 32'h1234_5678);
    ir_load(32'h1234_5678);
    sb_check();
    bus.state_alu = 1'b1; bus.iralu = 1'b1; bus.ir_q = 2'b11; bus.alu = 32'hDEAD_BEEF;
    exp_push(K_Q, "alu_state_hold", 32'h1234_5678);
    tick();
    sb_check();
    idle_inputs();

    // Shift left then shift right
    ir_load(32'h8000_0001);
    bus.iralu = 1'b1; bus.ir_q = 2'b01; bus.alu = 32'h0000_0000;
    #1;
    exp_push(K_SEL, "sel_shl", 32'h1);
    sb_check();
    bus.state_write = 1'b1;
    exp_push(K_Q, "shl", 32'h0000_0003);
    tick();
    sb_check();
    bus.ir_q = 2'b10; bus.alu = 32'h0000_0001;
    exp_push(K_Q, "shr", 32'h8000_0001);
    tick();
    sb_check();

    // iralu low masks the IR field
    bus.iralu = 1'b0; bus.ir_q = 2'b11; bus.alu = 32'hFFFF_FFFF;
    #1;
    exp_push(K_SEL, "sel_masked", 32'h0);
    sb_check();
    exp_push(K_Q, "masked_hold", 32'h8000_0001);
    tick();
    sb_check();
    idle_inputs();

    // qdrive across each state, then with no state
    bus.srcq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      st = 4'b0001 << i;
      {bus.state_fetch, bus.state_mmu, bus.state_write, bus.state_alu} = st;
      #1;
      exp_push(K_DRV, $sformatf("qdrive_st%0d", i), 32'h1);
      sb_check();
    end
    {bus.state_fetch, bus.state_mmu, bus.state_write, bus.state_alu} = 4'b0000;
    #1;
    exp_push(K_DRV, "qdrive_none", 32'h0);
    sb_check();
    idle_inputs();
    tick();

    // Three-step left sequence from q=1 inserting zeros, writes every other cycle
    ir_load(32'h0000_0001);
    bus.alu = 32'hFFFF_FFFF;
    bus.seq_start = 1'b1; bus.seq_dir = 1'b0; bus.seq_count = 6'd3;
    tick();
    bus.seq_start = 1'b0;
    exp_push(K_BUSY, "seq_busy_rise", 32'h1);
    exp_push(K_SEL,  "seq_sel",       32'h1);
    sb_check();
    dones = 0; busy_writes = 0;
    for (int i = 0; i < 10; i++) begin
      bus.state_write = (i % 2 == 0);
      // IR load mid-run must be ignored
      bus.iralu = (i == 2); bus.ir_q = (i == 2) ? 2'b11 : 2'b00;
      if (bus.seq_busy && bus.state_write) busy_writes++;
      tick();
      if (bus.seq_done) dones++;
    end
    idle_inputs();
    chk("seq3_busy_writes", busy_writes, 32'd3);
    chk("seq3_done_count", dones, 32'd1);
    exp_push(K_Q,    "seq3_q",    32'h0000_0008);
    exp_push(K_BUSY, "seq3_idle", 32'h0);
    sb_check();

    // Zero-count start: done only, never busy, Q untouched
    bus.seq_start = 1'b1; bus.seq_count = '0; bus.state_write = 1'b1;
    tick();
    bus.seq_start = 1'b0; bus.state_write = 1'b0;
    exp_push(K_DONE, "zero_done",  32'h1);
    exp_push(K_BUSY, "zero_busy",  32'h0);
    exp_push(K_Q,    "zero_q",     32'h0000_0008);
    sb_check();
    tick();
    exp_push(K_DONE, "zero_done_clr", 32'h0);
    sb_check();

    // Start during RUN is not a reload: 2 right steps with a held 7-count start
    bus.alu = 32'h0;
    bus.seq_start = 1'b1; bus.seq_dir = 1'b1; bus.seq_count = 6'd2;
    tick();
    bus.seq_count = 6'd7; bus.state_write = 1'b1;
    exp_push(K_Q, "run_step1", 32'h0000_0004);
    tick();
    sb_check();
    bus.seq_start = 1'b0;
    exp_push(K_Q,    "run_step2", 32'h0000_0002);
    exp_push(K_BUSY, "run_noreload_busy", 32'h0);
    exp_push(K_DONE, "run_noreload_done", 32'h1);
    tick();
    sb_check();
    idle_inputs();

    // Start coinciding with an IDLE write: IR load wins, shift on next write
    bus.iralu = 1'b1; bus.ir_q = 2'b11; bus.alu = 32'h0000_0005;
    bus.seq_start = 1'b1; bus.seq_dir = 1'b0; bus.seq_count = 6'd1; bus.state_write = 1'b1;
    exp_push(K_Q,    "same_edge_load", 32'h0000_0005);
    exp_push(K_BUSY, "same_edge_busy", 32'h1);
    tick();
    sb_check();
    bus.seq_start = 1'b0; bus.alu = 32'h0;
    exp_push(K_Q, "same_edge_shift", 32'h0000_000B);
    tick();
    sb_check();
    idle_inputs();
    tick();

    // Reset mid-sequence after two of five steps
    ir_load(32'h0000_0001);
    bus.alu = 32'h0;
    bus.seq_start = 1'b1; bus.seq_dir = 1'b0; bus.seq_count = 6'd5;
    tick();
    bus.seq_start = 1'b0; bus.state_write = 1'b1;
    tick(); tick();
    exp_push(K_Q, "mid_q", 32'h0000_0007);
    sb_check();
    reset = 1'b1;
    exp_push(K_Q,    "mid_rst_q",    32'h0);
    exp_push(K_BUSY, "mid_rst_busy", 32'h0);
    exp_push(K_DONE, "mid_rst_done", 32'h0);
    tick();
    sb_check();
    reset = 1'b0; bus.state_write = 1'b0;
    busy_seen = 0; dones = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.seq_busy) busy_seen++;
      if (bus.seq_done) dones++;
    end
    chk("post_rst_busy", busy_seen, 32'd0);
    chk("post_rst_done", dones, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/qreg_ctl.md
Name: qreg_ctl

Overview:
- Parametrised successor to the Q-register control logic. It now holds the Q register itself, not just its select lines.
- Decodes the IR Q-control field into hold/shift-left/shift-right/load, applies it on the write state and drives Q onto the M source bus.
- New: an autonomous shift sequencer that applies N consecutive shift steps for multiply/divide step loops without IR involvement.
- Sits beside the ALU; takes ALU output as its data input; feeds Q to the source mux.

Parameters:
- WIDTH, 32, width of Q and of the ALU data input.
- CNT_W, 6, width of the sequencer step counter; maximum steps = 2^CNT_W-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- state_alu  input  1  machine in ALU state.
- state_write  input  1  machine in WRITE state; the only state in which Q updates.
- state_mmu  input  1  machine in MMU state.
- state_fetch  input  1  machine in FETCH state.
- ir_q  input  2  IR Q-control field (IR bits 1:0).
- iralu  input  1  current instruction is an ALU instruction.
- srcq  input  1  Q selected as M source.
- alu  input  WIDTH  ALU result.
- seq_start  input  1  start-sequence pulse.
- seq_dir  input  1  sequence direction: 0 = shift left, 1 = shift right.
- seq_count  input  CNT_W  number of shift steps.
- q  output  WIDTH  Q register contents.
- qs0  output  1  effective select bit 0.
- qs1  output  1  effective select bit 1.
- qdrive  output  1  drive Q onto the source bus.
- seq_busy  output  1  sequencer active.
- seq_done  output  1  one-cycle pulse when a sequence completes.

Behaviour:
- Encoding of {qs1,qs0}: 00 hold; 01 shift left; 10 shift right; 11 load.
- Operations:
  - Shift left: q <= {q[WIDTH-2:0], ~alu[WIDTH-1]}.
  - Shift right: q <= {alu[0], q[WIDTH-1:1]}.
  - Load: q <= alu.
- Effective select, combinational:
  - seq_busy=1: {qs1,qs0} = seq_dir ? 10 : 01.
  - Otherwise: {qs1,qs0} = ir_q & {2{iralu}}.
- Q update: on the clk edge when state_write=1, apply the effective op. Q is unchanged in all other states.
- qdrive = srcq & (state_alu | state_write | state_mmu | state_fetch). It is combinational and unaffected by the sequencer.
- Sequencer state machine, states IDLE and RUN:
  - IDLE, seq_start=1, seq_count!=0: latch seq_dir and seq_count into the counter; go to RUN. seq_busy=1 from the next cycle.
  - IDLE, seq_start=1, seq_count=0: stay IDLE; seq_done=1 next cycle; Q untouched.
  - RUN, state_write=1: apply one shift and decrement the counter. If the counter was 1, go to IDLE and pulse seq_done in the following cycle.
  - RUN, state_write=0: no change.
  - seq_start while RUN: ignored. iralu Q ops while RUN: ignored, because the sequencer owns the selects.
  - A seq_start in the same cycle as a state_write in IDLE: the IR op executes on that edge; the sequence starts and its first shift occurs on the next state_write.
- Latency:
  - Q changes on the edge ending the state_write cycle and is visible the next cycle.
  - A sequence of N steps occupies exactly N state_write cycles after the start edge.
- Reset, synchronous and dominant over all other inputs, including mid-sequence:
  - q = 0, sequencer IDLE, counter = 0, seq_busy = 0, seq_done = 0.
  - qs0/qs1/qdrive follow their combinational inputs.

Decomposition:
- Shared package: Q-op encodings (Q_HOLD=2'b00, Q_SHL=2'b01, Q_SHR=2'b10, Q_LOAD=2'b11) and sequencer state encodings (SEQ_IDLE, SEQ_RUN).
- One natural sub-module: qreg_seq, holding the sequencer state machine and counter. It outputs seq_busy, seq_done and the override select. The Q datapath and qdrive remain in the top module.

Test Plan:
- Reset, then iralu=1, ir_q=11, alu=32'h1234_5678, state_write=1 -> next cycle q=32'h1234_5678; with state_alu only, q is unchanged.
- q=32'h8000_0001, ir_q=01, alu[31]=0, state_write -> q=32'h0000_0003. Then ir_q=10, alu[0]=1 -> q=32'h8000_0001.
- iralu=0, ir_q=11 -> qs1=qs0=0 and q holds. srcq=1 in each of the four states -> qdrive=1; srcq=1 with no state asserted -> qdrive=0.
- seq_start with seq_dir=0, seq_count=3, q=1, alu[31]=1, state_write every other cycle:
  - seq_busy high across 3 write cycles; q=8 at the end.
  - seq_done pulses once; IR load issued mid-run is ignored.
- seq_count=0 -> seq_done pulse, seq_busy never rises, q unchanged. seq_start during RUN -> counter is not reloaded.
- reset asserted mid-sequence (count 5, after 2 steps) -> next cycle q=0, seq_busy=0, no seq_done pulse.
